uart_rx_fifo: RTL and testbench



---
 rtl/uart_pkg.sv | 11 +
 rtl/uart_rx_fifo_ram.sv | 27 ++
 rtl/uart_rx_fifo.sv | 127 ++++++++++++
 tb/tb_uart_rx_fifo.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types for the UART receive path: the buffered entry layout and data width.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef struct packed {
        logic                   err;
        logic [UART_DATA_W-1:0] data;
    } rx_entry_t;

endpackage

// File: rtl/uart_rx_fifo_ram.sv
// Entry storage for uart_rx_fifo: one synchronous write port, one asynchronous read port.
// Deliberately unreset; the pointers in the parent decide which words are meaningful.
module uart_rx_fifo_ram #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Write port: capture the pushed entry on the rising edge.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive buffer behind the UART receiver, with level, full/empty
// and sticky overflow. Define UART_RX_FIFO_ERRTAG_EN to store frame-error bytes with a tag.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clk50m,
    input  logic                     rst,
    input  logic [7:0]               rx_data,
    input  logic                     rx_ready,
    input  logic                     rx_error,
    output logic [7:0]               rd_data,
    output logic                     rd_err,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow,
    input  logic                     ovf_clr
);

    localparam int AW = $clog2(DEPTH);
`ifdef UART_RX_FIFO_ERRTAG_EN
    localparam int ENTRY_W = $bits(rx_entry_t);
`else
    localparam int ENTRY_W = UART_DATA_W;
`endif
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]         wr_ptr_q, wr_ptr_d;
    logic [AW:0]         rd_ptr_q, rd_ptr_d;
    logic                overflow_q, overflow_d;
    logic                push_req_s;
    logic                pop_s;
    logic                wr_en_s;
    logic                drop_s;
    logic                full_s;
    logic                empty_s;
    logic [ENTRY_W-1:0]  wr_entry_s;
    logic [ENTRY_W-1:0]  head_entry_s;

`ifdef UART_RX_FIFO_ERRTAG_EN
    rx_entry_t wr_ent_s;
    rx_entry_t head_ent_s;

    assign push_req_s     = rx_ready | rx_error;
    assign wr_ent_s.err   = rx_error;
    assign wr_ent_s.data  = rx_data;
    assign wr_entry_s     = wr_ent_s;
    assign head_ent_s     = head_entry_s;
    assign rd_data        = head_ent_s.data;
    assign rd_err         = head_ent_s.err;
`else
    // A simultaneous error pulse marks the byte as bad, so it is not buffered.
    assign push_req_s     = rx_ready & ~rx_error;
    assign wr_entry_s     = rx_data;
    assign rd_data        = head_entry_s;
    assign rd_err         = 1'b0;
`endif

    assign empty_s = (wr_ptr_q == rd_ptr_q);
    assign full_s  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // When full, a same-cycle pop frees the slot the push overwrites.
    assign pop_s   = ~empty_s & rd_ready;
    assign wr_en_s = push_req_s & (~full_s | pop_s);
    assign drop_s  = push_req_s & full_s & ~pop_s;

    uart_rx_fifo_ram #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W),
        .AW    (AW)
    ) u_ram (
        .clk_i   (clk50m),
        .we_i    (wr_en_s),
        .waddr_i (wr_ptr_q[AW-1:0]),
        .wdata_i (wr_entry_s),
        .raddr_i (rd_ptr_q[AW-1:0]),
        .rdata_o (head_entry_s)
    );

    // Next-state for pointers and the sticky overflow flag.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q;
        if (wr_en_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        if (drop_s) begin
            overflow_d = 1'b1;
        end else if (ovf_clr) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // State registers.
    always_ff @(posedge clk50m or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= {(AW+1){1'b0}};
            rd_ptr_q   <= {(AW+1){1'b0}};
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
        end
    end

    assign level    = wr_ptr_q - rd_ptr_q;
    assign full     = full_s;
    assign empty    = empty_s;
    assign rd_valid = ~empty_s;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo (DEPTH=16), default or error-tag build.
module tb_uart_rx_fifo;

    logic       clk50m = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       rx_error;
    logic [7:0] rd_data;
    logic       rd_err;
    logic       rd_valid;
    logic       rd_ready;
    logic [4:0] level;
    logic       full;
    logic       empty;
    logic       overflow;
    logic       ovf_clr;

    int checks   = 0;
    int failures = 0;

    always #10 clk50m = ~clk50m;

    uart_rx_fifo #(.DEPTH(16)) dut (
        .clk50m   (clk50m),
        .rst      (rst),
        .rx_data  (rx_data),
        .rx_ready (rx_ready),
        .rx_error (rx_error),
        .rd_data  (rd_data),
        .rd_err   (rd_err),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .level    (level),
        .full     (full),
        .empty    (empty),
        .overflow (overflow),
        .ovf_clr  (ovf_clr)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk50m);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        rx_data  = b;
        rx_ready = 1'b1;
        step();
        rx_ready = 1'b0;
    endtask

    logic [7:0] q[$];
    logic [7:0] exp_b;

    initial begin
        rst = 1'b1; rx_data = 8'h00; rx_ready = 1'b0; rx_error = 1'b0;
        rd_ready = 1'b0; ovf_clr = 1'b0;
        step(); step();
        chk("rst_level", level, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_valid", rd_valid, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_err", rd_err, 0);
        rst = 1'b0;
        step();

        // Basic FWFT: three bytes, then drain.
        push(8'h41);
        chk("lat_valid", rd_valid, 1);
        chk("lat_level", level, 1);
        push(8'h42);
        push(8'h43);
        chk("abc_level", level, 3);
        chk("abc_head", rd_data, 8'h41);
        rd_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_b = 8'h41 + 8'(i);
            chk("abc_read", rd_data, exp_b);
            step();
        end
        rd_ready = 1'b0;
        chk("abc_empty", empty, 1);
        chk("abc_level0", level, 0);

        // Overflow: 17 bytes into 16 slots.
        for (int i = 0; i < 16; i++) push(8'(i));
        chk("fill_full", full, 1);
        chk("fill_ovf0", overflow, 0);
        push(8'h10);
        chk("ovf_full", full, 1);
        chk("ovf_level", level, 16);
        chk("ovf_set", overflow, 1);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        chk("ovf_clr", overflow, 0);

        // Push and pop together while full.
        chk("first_read", rd_data, 8'h00);
        rx_data = 8'hAA; rx_ready = 1'b1; rd_ready = 1'b1;
        step();
        rx_ready = 1'b0;
        chk("pp_level", level, 16);
        chk("pp_ovf", overflow, 0);
        chk("pp_full", full, 1);
        for (int i = 1; i < 17; i++) begin
            exp_b = (i == 16) ? 8'hAA : 8'(i);
            chk("pp_drain", rd_data, exp_b);
            step();
        end
        rd_ready = 1'b0;
        chk("pp_empty", empty, 1);

        // Frame-error byte, alone and together with rx_ready.
        rx_data = 8'h55; rx_error = 1'b1;
        step();
        rx_error = 1'b0;
`ifdef UART_RX_FIFO_ERRTAG_EN
        chk("err_valid", rd_valid, 1);
        chk("err_tag", rd_err, 1);
        chk("err_data", rd_data, 8'h55);
        rd_ready = 1'b1; step(); rd_ready = 1'b0;
        rx_data = 8'h66; rx_ready = 1'b1; rx_error = 1'b1;
        step();
        rx_ready = 1'b0; rx_error = 1'b0;
        chk("both_level", level, 1);
        chk("both_tag", rd_err, 1);
        chk("both_data", rd_data, 8'h66);
        rd_ready = 1'b1; step(); rd_ready = 1'b0;
`else
        chk("err_level", level, 0);
        chk("err_valid", rd_valid, 0);
        rx_data = 8'h66; rx_ready = 1'b1; rx_error = 1'b1;
        step();
        rx_ready = 1'b0; rx_error = 1'b0;
        chk("both_level", level, 0);
        chk("both_ovf", overflow, 0);
`endif
        chk("err_empty", empty, 1);

        // 40 bytes with random consumer across pointer wrap.
        begin
            int pushed = 0;
            for (int cyc = 0; cyc < 600 && (pushed < 40 || q.size() > 0); cyc++) begin
                logic do_push, do_pop;
                do_push  = (pushed < 40) && ($urandom_range(3) != 0);
                rd_ready = ($urandom_range(1) == 1);
                do_pop   = rd_ready && (q.size() > 0);
                if (do_push && q.size() == 16 && !do_pop) do_push = 1'b0;
                rx_data  = 8'h80 + 8'(pushed);
                rx_ready = do_push;
                if (do_pop) chk("rnd_data", rd_data, q[0]);
                step();
                if (do_pop) void'(q.pop_front());
                if (do_push) begin
                    q.push_back(rx_data);
                    pushed++;
                end
                chk("rnd_level", level, q.size());
            end
            rx_ready = 1'b0; rd_ready = 1'b0;
            chk("rnd_empty", empty, 1);
            chk("rnd_ovf", overflow, 0);
        end

        // Mid-stream asynchronous reset with overflow pending.
        for (int i = 0; i < 17; i++) push(8'h20 + 8'(i));
        rd_ready = 1'b1;
        for (int i = 0; i < 11; i++) step();
        rd_ready = 1'b0;
        chk("pre_rst_level", level, 5);
        chk("pre_rst_ovf", overflow, 1);
        #5 rst = 1'b1;
        #1;
        chk("arst_level", level, 0);
        chk("arst_valid", rd_valid, 0);
        chk("arst_ovf", overflow, 0);
        chk("arst_empty", empty, 1);
        step();
        rst = 1'b0;
        push(8'h7E);
        chk("post_level", level, 1);
        chk("post_data", rd_data, 8'h7E);
        chk("post_err", rd_err, 0);
        rd_ready = 1'b1; step(); rd_ready = 1'b0;
        chk("post_empty", empty, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
